// File: rtl/shared_adder_arbiter.sv
// shared_adder_arbiter
// Shares one registered adder among NUM_REQ requesters using a round-robin
// arbiter and a valid/ready request handshake. Each accepted operand pair goes
// through two stages. The first stage registers the operands and the tag. The
// second stage registers the widened sum. The result leaves as a one-cycle
// tagged pulse, and the response side has no backpressure.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous active-high reset
//   en          grant enable; when low, no new grants are issued and the pipe drains
//   req_valid   [NUM_REQ]              per-requester request valid
//   req_ready   [NUM_REQ]              combinational grant, one-hot or zero
//   req_a/req_b [NUM_REQ*ADDER_WIDTH]  packed operands, requester i at [i*ADDER_WIDTH +: ADDER_WIDTH]
//   resp_valid  result pulse
//   resp_id     [ID_WIDTH]             owner of the result
//   resp_sum    [ADDER_WIDTH+1]        zero-extended a+b including the carry-out
//   busy        high while either pipeline stage holds a valid entry
module shared_adder_arbiter #(
  parameter int ADDER_WIDTH = 39,
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic [NUM_REQ-1:0]               req_valid,
  output logic [NUM_REQ-1:0]               req_ready,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*ADDER_WIDTH-1:0]   req_b,
  output logic                             resp_valid,
  output logic [ID_WIDTH-1:0]              resp_id,
  output logic [ADDER_WIDTH:0]             resp_sum,
  output logic                             busy
);

  logic [ID_WIDTH-1:0]    rr_ptr;
  logic [NUM_REQ-1:0]     grant;
  logic [ID_WIDTH-1:0]    gnt_id;
  logic                   xfer;
  logic [ADDER_WIDTH-1:0] sel_a;
  logic [ADDER_WIDTH-1:0] sel_b;

  logic [ADDER_WIDTH-1:0] a_p1;
  logic [ADDER_WIDTH-1:0] b_p1;
  logic [ID_WIDTH-1:0]    id_p1;
  logic                   vld_p1;

  // Add at full width so that the carry-out lands in the top bit.
  function automatic logic [ADDER_WIDTH:0] add_ext(input logic [ADDER_WIDTH-1:0] x,
                                                   input logic [ADDER_WIDTH-1:0] y);
    return {1'b0, x} + {1'b0, y};
  endfunction

  // The search order is rr_ptr, rr_ptr+1, ... (mod NUM_REQ). Candidates are
  // visited from farthest to nearest, so the nearest valid requester is the
  // last one written and wins.
  always_comb begin
    grant  = '0;
    gnt_id = '0;
    if (en && !rst) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        for (int i = 0; i < NUM_REQ; i++) begin
          if ((i == (int'(rr_ptr) + k) % NUM_REQ) && req_valid[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
            gnt_id   = ID_WIDTH'(i);
          end
        end
      end
    end
  end

  assign req_ready = grant;
  assign xfer      = |grant;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_a = req_a[i*ADDER_WIDTH +: ADDER_WIDTH];
        sel_b = req_b[i*ADDER_WIDTH +: ADDER_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (xfer) begin
      rr_ptr <= (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + ID_WIDTH'(1);
    end
  end

  // Stage p1: operand register, loaded only on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_p1   <= '0;
      b_p1   <= '0;
      id_p1  <= '0;
      vld_p1 <= 1'b0;
    end else begin
      vld_p1 <= xfer;
      if (xfer) begin
        a_p1  <= sel_a;
        b_p1  <= sel_b;
        id_p1 <= gnt_id;
      end
    end
  end

  // Stage p2: sum register. The sum and the tag hold their values between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_sum   <= '0;
    end else begin
      resp_valid <= vld_p1;
      if (vld_p1) begin
        resp_id  <= id_p1;
        resp_sum <= add_ext(a_p1, b_p1);
      end
    end
  end

  assign busy = vld_p1 | resp_valid;

endmodule

// File: tb/tb_shared_adder_arbiter.sv
// Directed-vector bench for shared_adder_arbiter. The stimulus process queues
// the expected tag and sum for each transfer. A monitor pops an entry from the
// queue and compares it whenever resp_valid is high.
module tb_shared_adder_arbiter;
  localparam int AW = 39;
  localparam int NR = 4;
  localparam int IW = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*AW-1:0]  req_a;
  logic [NR*AW-1:0]  req_b;
  logic              resp_valid;
  logic [IW-1:0]     resp_id;
  logic [AW:0]       resp_sum;
  logic              busy;

  logic [AW-1:0] a [NR];
  logic [AW-1:0] b [NR];

  logic [IW+AW:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  shared_adder_arbiter #(.ADDER_WIDTH(AW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_sum(resp_sum),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_a = '0;
    req_b = '0;
    for (int i = 0; i < NR; i++) begin
      req_a[i*AW +: AW] = a[i];
      req_b[i*AW +: AW] = b[i];
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW:0] model_sum(input int i);
    return {1'b0, a[i]} + {1'b0, b[i]};
  endfunction

  task automatic expect_grant(input int id, input logic [AW:0] sum, input string name);
    #1;
    check(name, 64'(req_ready), 64'(4'b0001 << id));
    exp_q.push_back({IW'(id), sum});
  endtask

  // Monitor: compares each response pulse with the head of the queue.
  always @(negedge clk) begin
    if (resp_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_resp", 64'(resp_valid), 64'd0);
      end else begin
        logic [IW+AW:0] e;
        e = exp_q.pop_front();
        check("resp_id", 64'(resp_id), 64'(e[IW+AW:AW+1]));
        check("resp_sum", 64'(resp_sum), 64'(e[AW:0]));
      end
    end
  end

  initial begin
    rst = 1'b1; en = 1'b1; req_valid = 4'b1111;
    a[0] = 39'd5;              b[0] = 39'd7;
    a[1] = 39'h7F_FFFF_FF00;   b[1] = 39'h00_0000_0100;
    a[2] = 39'h7F_FFFF_FFFF;   b[2] = 39'd1;
    a[3] = 39'h00_0000_0000;   b[3] = 39'h55_5555_5555;
    #2;
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_resp_sum", 64'(resp_sum), 64'd0);
    check("rst_resp_id", 64'(resp_id), 64'd0);
    check("rst_ready", 64'(req_ready), 64'd0);
    tick(); tick();
    check("rst_ready_after_edges", 64'(req_ready), 64'd0);
    req_valid = 4'b0000;
    rst = 1'b0;
    tick();

    // Single operation: 5 + 7 from requester 0.
    req_valid = 4'b0001;
    expect_grant(0, 40'd12, "single_ready");
    tick();
    req_valid = 4'b0000;
    check("single_busy_t", 64'(busy), 64'd1);
    tick();
    check("single_busy_t1", 64'(busy), 64'd1);
    tick();
    check("single_pulse_end", 64'(resp_valid), 64'd0);
    check("single_sum_hold", 64'(resp_sum), 64'd12);
    check("single_busy_idle", 64'(busy), 64'd0);

    // Carry-out: the pointer is at 1, so requester 2 is granted.
    req_valid = 4'b0100;
    expect_grant(2, 40'h80_0000_0000, "carry_ready");
    tick();

    // The pointer is now 3. It wraps to 0, skips 1 and 3, and so grants 0, 2, 0.
    req_valid = 4'b0101;
    expect_grant(0, 40'd12, "wrap_g0");
    tick();
    expect_grant(2, 40'h80_0000_0000, "wrap_g2");
    tick();
    expect_grant(0, 40'd12, "wrap_g0b");
    tick();

    // The pointer is 1. A lone request from 3 returns the pointer to 0.
    req_valid = 4'b1000;
    expect_grant(3, 40'h55_5555_5555, "skip_g3");
    tick();

    // Round robin with distinct operands.
    a[0] = 39'h12_3456_789A;   b[0] = 39'h01_1111_1111;
    a[2] = 39'h40_0000_0000;   b[2] = 39'h3F_0000_0001;
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      expect_grant(k % NR, model_sum(k % NR), "rr_ready");
      tick();
      if (k > 0) check("rr_busy", 64'(busy), 64'd1);
    end

    // The last transfer is to 0 and moves the pointer to 1. en then drops.
    req_valid = 4'b0001;
    expect_grant(0, 40'h13_4567_89AB, "last_ready");
    tick();
    en = 1'b0;
    req_valid = 4'b1111;
    #1;
    check("en0_ready", 64'(req_ready), 64'd0);
    check("en0_busy0", 64'(busy), 64'd1);
    tick();
    check("en0_ready1", 64'(req_ready), 64'd0);
    check("en0_busy1", 64'(busy), 64'd1);
    tick();
    check("en0_busy2", 64'(busy), 64'd0);
    tick();
    en = 1'b1;
    #1;
    check("en1_ptr_held", 64'(req_ready), 64'd2);
    tick();
    req_valid = 4'b0000;

    // Asynchronous reset between the transfer edge and the response edge.
    #2;
    rst = 1'b1;
    #1;
    check("arst_resp_valid", 64'(resp_valid), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_resp_sum", 64'(resp_sum), 64'd0);
    check("arst_resp_id", 64'(resp_id), 64'd0);
    tick(); tick();
    rst = 1'b0;
    tick();
    check("arst_no_pulse", 64'(resp_valid), 64'd0);
    req_valid = 4'b1111;
    expect_grant(0, 40'h13_4567_89AB, "arst_first_grant");
    tick();
    req_valid = 4'b0000;

    for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
    tick(); tick();
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
